fetch_sched: RTL and testbench
==============================

FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 Parameter: H_TOTAL, 800, clocks per line.
REQ-002 Parameter: H_ACTIVE, 640, active clocks per line.
REQ-003 Parameter: V_TOTAL, 525, lines per frame.
REQ-004 Parameter: V_ACTIVE, 480, active lines per frame.
REQ-005 Parameter: IMG_W / IMG_H, 450 / 450, upscaled image window size.
REQ-006 Parameter: H_OFFSET / V_OFFSET, 95 / 15, window origin within the active area.
REQ-007 Parameter: PREFILL_CYC, 256, clocks between frame reset release and scan start.
REQ-008 Port: clk  input  1  single system clock (all logic rising edge).
REQ-009 Port: rst_n  input  1  asynchronous active-low reset.
REQ-010 Port: i_en  input  1  scanning enable, level.
REQ-011 Port: i_valid  input  1  loader has pixel data.
REQ-012 Port: o_next  output  1  pixel request to the loader.
REQ-013 Port: o_vsync  output  1  active-low frame reset to the loader.
REQ-014 Port: o_de  output  1  inside H_ACTIVE x V_ACTIVE.
REQ-015 Port: o_in_img  output  1  inside the image window.
REQ-016 Port: o_hcnt / o_vcnt  output  10 / 10  scan counters.
REQ-017 Port: o_state  output  2  FSM state, encoded IDLE=0, FRST=1, PREFILL=2, SCAN=3.
REQ-018 Port: o_underflow  output  1  sticky underflow flag.
REQ-019 Port: i_clr_err  input  1  clears o_underflow.
REQ-020 Port: o_frame_cnt  output  8  completed frames, wraps 255->0.
REQ-021 Port: o_uf_cnt  output  16  underflow event count (see Configuration).

Function
REQ-022 IDLE: counters held at 0; o_vsync=0; advance to FRST when i_en=1.
REQ-023 FRST: o_vsync=0 for exactly 2 clocks; then PREFILL.
REQ-024 PREFILL: o_vsync=1; counters held at 0; lasts exactly PREFILL_CYC clocks; then SCAN.
REQ-025 SCAN: o_vsync=1; o_hcnt increments every clock and wraps H_TOTAL-1->0; o_vcnt increments on each h wrap.
REQ-026 End of frame (o_hcnt=H_TOTAL-1, o_vcnt=V_TOTAL-1) in SCAN: o_frame_cnt +1; next state FRST if i_en=1, else IDLE.
REQ-027 i_en deasserted mid-frame: the current frame completes; i_en is sampled only in IDLE and at end of frame.
REQ-028 o_de = SCAN && hcnt<H_ACTIVE && vcnt<V_ACTIVE; combinational from registered state.
REQ-029 o_in_img = SCAN && H_OFFSET<=hcnt<H_OFFSET+IMG_W && V_OFFSET<=vcnt<V_OFFSET+IMG_H.
REQ-030 o_next = o_in_img && i_valid; combinational; zero latency; exactly one request per asserted clock.
REQ-031 Underflow event = o_in_img && !i_valid; o_next stays 0 and the scan does not stall.
REQ-032 o_underflow is set on the clock after an event; cleared by i_clr_err; simultaneous set and clear resolves to set.
REQ-033 Maximum requests per frame = IMG_W*IMG_H; no requests outside SCAN.

Reset
REQ-034 rst_n=0 asynchronously forces: IDLE, counters 0, o_frame_cnt 0, o_underflow 0, o_uf_cnt 0.
REQ-035 Resulting outputs during reset: o_vsync=0, o_next=0, o_de=0, o_in_img=0.
REQ-036 Reset asserted mid-frame aborts the frame immediately; after release the FSM restarts from IDLE.

Configuration
REQ-037 Macro FETCH_SCHED_UF_CNT_EN defined: o_uf_cnt counts underflow events, saturates at 16'hFFFF, and is cleared by i_clr_err (clear has priority over increment).
REQ-038 Macro FETCH_SCHED_UF_CNT_EN undefined: no counter logic is built; o_uf_cnt is tied to 0.

Verification
REQ-039 All scenarios use H_TOTAL=20, H_ACTIVE=16, V_TOTAL=12, V_ACTIVE=10, IMG_W=8, IMG_H=6, H_OFFSET=4, V_OFFSET=2, PREFILL_CYC=5.
REQ-040 Start-up: i_en=1 from reset release -> o_vsync low 2 clocks, PREFILL 5 clocks, SCAN starts at clock 8.
REQ-041 Full frame: i_valid=1 -> exactly 48 o_next pulses; o_frame_cnt=1 after 240 SCAN clocks.
REQ-042 Underflow: i_valid=0 at hcnt=5, vcnt=3 -> o_next=0; o_underflow=1 next clock; o_uf_cnt=1 when the macro is defined.
REQ-043 Stop: i_en dropped at vcnt=4 -> frame finishes; state IDLE; o_frame_cnt=1; o_vsync=0.
REQ-044 Reset at vcnt=5 -> all outputs at reset values within the same clock; restart from IDLE after release.
REQ-045 Simultaneous i_clr_err and underflow event -> o_underflow remains 1.

Source files
------------

// File: rtl/fetch_sched_if.sv
// fetch_sched_if: loader-facing scan/fetch bus between fetch_sched (slave) and the pixel loader (master).
interface fetch_sched_if;
  logic       i_valid;
  logic       o_next;
  logic       o_vsync;
  logic       o_de;
  logic       o_in_img;
  logic [9:0] o_hcnt;
  logic [9:0] o_vcnt;
  modport slave (input i_valid, output o_next, o_vsync, o_de, o_in_img, o_hcnt, o_vcnt);
  modport master(output i_valid, input o_next, o_vsync, o_de, o_in_img, o_hcnt, o_vcnt);
endinterface

// File: rtl/fetch_sched.sv
// fetch_sched: raster scan scheduler issuing zero-latency pixel requests inside the image window.
// Define FETCH_SCHED_UF_CNT_EN to build the saturating underflow event counter on o_uf_cnt.
module fetch_sched #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int IMG_W       = 450,
  parameter int IMG_H       = 450,
  parameter int H_OFFSET    = 95,
  parameter int V_OFFSET    = 15,
  parameter int PREFILL_CYC = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr_err,
  fetch_sched_if.slave  bus,
  output logic [1:0]    o_state,
  output logic          o_underflow,
  output logic [7:0]    o_frame_cnt,
  output logic [15:0]   o_uf_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FRST = 2'd1, PREFILL = 2'd2, SCAN = 2'd3;
  localparam int PW = $clog2(PREFILL_CYC > 2 ? PREFILL_CYC : 2);
  localparam logic [PW-1:0] PL = PW'(PREFILL_CYC - 1);
  localparam logic [9:0] HT = 10'(H_TOTAL - 1), VT = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE), VA = 10'(V_ACTIVE);
  localparam logic [9:0] HO = 10'(H_OFFSET), HE = 10'(H_OFFSET + IMG_W);
  localparam logic [9:0] VO = 10'(V_OFFSET), VE = 10'(V_OFFSET + IMG_H);
  logic [1:0]    r_state, w_nstate;
  logic [PW-1:0] r_pcnt;
  logic [9:0]    r_hcnt, r_vcnt;
  logic [7:0]    r_frame_cnt;
  logic          r_underflow;
  logic          w_scan, w_eof, w_pdone, w_in_img, w_uf;
  assign w_scan  = r_state == SCAN;
  assign w_eof   = w_scan && r_hcnt == HT && r_vcnt == VT;
  // FRST and PREFILL share one dwell counter, restarted on every state change
  assign w_pdone = (r_state == FRST && r_pcnt == PW'(1)) || (r_state == PREFILL && r_pcnt == PL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  always_comb
    w_nstate = (r_state == IDLE || w_eof) ? (i_en ? FRST : IDLE) :
               w_pdone                    ? r_state + 2'd1       : r_state;
  always_comb begin
    w_in_img      = w_scan && r_hcnt >= HO && r_hcnt < HE && r_vcnt >= VO && r_vcnt < VE;
    w_uf          = w_in_img && !bus.i_valid;
    bus.o_vsync   = r_state[1];
    bus.o_de      = w_scan && r_hcnt < HA && r_vcnt < VA;
    bus.o_in_img  = w_in_img;
    bus.o_next    = w_in_img && bus.i_valid;
    bus.o_hcnt    = r_hcnt;
    bus.o_vcnt    = r_vcnt;
    o_state       = r_state;
    o_underflow   = r_underflow;
    o_frame_cnt   = r_frame_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pcnt      <= '0;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_pcnt      <= (w_nstate != r_state || w_scan) ? '0 : r_pcnt + 1'b1;
      r_hcnt      <= (!w_scan || w_eof || r_hcnt == HT) ? '0 : r_hcnt + 1'b1;
      r_vcnt      <= (!w_scan || w_eof) ? '0 : (r_hcnt == HT) ? r_vcnt + 1'b1 : r_vcnt;
      r_frame_cnt <= w_eof ? r_frame_cnt + 1'b1 : r_frame_cnt;
      r_underflow <= w_uf ? 1'b1 : i_clr_err ? 1'b0 : r_underflow;
    end
`ifdef FETCH_SCHED_UF_CNT_EN
  logic [15:0] r_uf_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_uf_cnt <= '0;
    else        r_uf_cnt <= i_clr_err ? '0 : (w_uf && r_uf_cnt != 16'hFFFF) ? r_uf_cnt + 1'b1 : r_uf_cnt;
  assign o_uf_cnt = r_uf_cnt;
`else
  assign o_uf_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed scoreboard bench; stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_fetch_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_clr_err = 1'b0;
  logic [1:0]  o_state;
  logic        o_underflow;
  logic [7:0]  o_frame_cnt;
  logic [15:0] o_uf_cnt;
  fetch_sched_if bus();
  fetch_sched #(
    .H_TOTAL(20), .H_ACTIVE(16), .V_TOTAL(12), .V_ACTIVE(10),
    .IMG_W(8), .IMG_H(6), .H_OFFSET(4), .V_OFFSET(2), .PREFILL_CYC(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_clr_err(i_clr_err), .bus(bus.slave),
    .o_state(o_state), .o_underflow(o_underflow), .o_frame_cnt(o_frame_cnt), .o_uf_cnt(o_uf_cnt)
  );
  always #5 clk = ~clk;
`ifdef FETCH_SCHED_UF_CNT_EN
  localparam int U = 1;
`else
  localparam int U = 0;
`endif
  localparam int ST = 0, VS = 1, NX = 2, DE = 3, IM = 4, HC = 5, VC = 6, UF = 7, FC = 8, UC = 9, NC = 10;
  typedef struct {int cyc; string name; int sel; int val;} exp_t;
  exp_t q[$];
  int cyc = 0, nxt_cnt = 0, checks = 0, errors = 0;
  int c0, f1, f2, f3;
  function automatic int dut_val(int sel);
    case (sel)
      ST: return int'(o_state);
      VS: return int'(bus.o_vsync);
      NX: return int'(bus.o_next);
      DE: return int'(bus.o_de);
      IM: return int'(bus.o_in_img);
      HC: return int'(bus.o_hcnt);
      VC: return int'(bus.o_vcnt);
      UF: return int'(o_underflow);
      FC: return int'(o_frame_cnt);
      UC: return int'(o_uf_cnt);
      default: return nxt_cnt;
    endcase
  endfunction
  task automatic push(int c, string n, int s, int v);
    exp_t e;
    e.cyc = c; e.name = n; e.sel = s; e.val = v;
    q.push_back(e);
  endtask
  task automatic wait_until(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    exp_t e;
    int got;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      got = dut_val(e.sel);
      checks++;
      if (e.cyc != cyc || got != e.val) begin
        errors++;
        $display("FAIL %s at cycle %0d (due %0d): got %0d expected %0d", e.name, cyc, e.cyc, got, e.val);
      end
    end
    nxt_cnt += int'(bus.o_next);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    push(cyc, "rst_state", ST, 0);   push(cyc, "rst_vsync", VS, 0);  push(cyc, "rst_next", NX, 0);
    push(cyc, "rst_de", DE, 0);      push(cyc, "rst_in_img", IM, 0); push(cyc, "rst_hcnt", HC, 0);
    push(cyc, "rst_vcnt", VC, 0);    push(cyc, "rst_uf", UF, 0);     push(cyc, "rst_fcnt", FC, 0);
    push(cyc, "rst_ufcnt", UC, 0);
    @(posedge clk); #1;
    c0 = cyc; f1 = c0 + 8; f2 = c0 + 255; f3 = c0 + 508;
    rst_n = 1'b1; i_en = 1'b1;
    push(c0, "idle_state", ST, 0);      push(c0, "idle_vsync", VS, 0);
    push(c0 + 1, "frst1_state", ST, 1); push(c0 + 1, "frst1_vsync", VS, 0);
    push(c0 + 2, "frst2_state", ST, 1); push(c0 + 2, "frst2_vsync", VS, 0);
    push(c0 + 3, "pre_state", ST, 2);   push(c0 + 3, "pre_vsync", VS, 1); push(c0 + 3, "pre_hcnt", HC, 0);
    push(c0 + 7, "pre_last", ST, 2);
    push(f1, "scan_start", ST, 3);      push(f1, "scan_h0", HC, 0);       push(f1, "scan_v0", VC, 0);
    push(f1, "scan_vsync", VS, 1);
    push(f1 + 15, "de_h15", DE, 1);     push(f1 + 16, "de_h16", DE, 0);
    push(f1 + 19, "hcnt_19", HC, 19);   push(f1 + 20, "hcnt_wrap", HC, 0); push(f1 + 20, "vcnt_inc", VC, 1);
    push(f1 + 43, "img_h3", IM, 0);     push(f1 + 44, "img_h4v2", IM, 1);  push(f1 + 44, "next_h4v2", NX, 1);
    push(f1 + 151, "img_h11v7", IM, 1); push(f1 + 152, "img_h12", IM, 0);  push(f1 + 164, "img_v8", IM, 0);
    push(f1 + 180, "de_v9", DE, 1);     push(f1 + 200, "de_v10", DE, 0);
    push(f1 + 239, "eof_h", HC, 19);    push(f1 + 239, "eof_v", VC, 11);   push(f1 + 239, "eof_fcnt", FC, 0);
    push(f1 + 239, "eof_state", ST, 3);
    push(f1 + 240, "f1_next_frst", ST, 1); push(f1 + 240, "f1_fcnt", FC, 1); push(f1 + 240, "f1_pulses", NC, 48);
    push(f1 + 240, "f1_vsync_low", VS, 0); push(f1 + 240, "f1_hcnt_rst", HC, 0);
    push(f2, "f2_scan", ST, 3);
    push(f2 + 64, "f2_next_ok", NX, 1);
    push(f2 + 65, "uf_in_img", IM, 1);  push(f2 + 65, "uf_next", NX, 0);  push(f2 + 65, "uf_not_yet", UF, 0);
    push(f2 + 66, "uf_set", UF, 1);     push(f2 + 66, "ufcnt_1", UC, U);
    push(f2 + 68, "uf_clr", UF, 0);     push(f2 + 68, "ufcnt_clr", UC, 0);
    push(f2 + 71, "uf_set_wins", UF, 1); push(f2 + 71, "ufcnt_clr_wins", UC, 0);
    push(f2 + 200, "en_off_scan", ST, 3); push(f2 + 239, "en_off_last", ST, 3);
    push(f2 + 240, "stop_idle", ST, 0); push(f2 + 240, "stop_vsync", VS, 0); push(f2 + 240, "stop_fcnt", FC, 2);
    push(f2 + 240, "f2_pulses", NC, 94);
    push(c0 + 500, "idle_hold", ST, 0); push(c0 + 500, "idle_hcnt", HC, 0);
    push(f3, "f3_scan", ST, 3);
    push(f3 + 105, "f3_uf", UF, 1);     push(f3 + 105, "f3_ufcnt", UC, U); push(f3 + 105, "f3_fcnt", FC, 2);
    push(f3 + 106, "ar_state", ST, 0);  push(f3 + 106, "ar_vsync", VS, 0); push(f3 + 106, "ar_next", NX, 0);
    push(f3 + 106, "ar_de", DE, 0);     push(f3 + 106, "ar_in_img", IM, 0); push(f3 + 106, "ar_hcnt", HC, 0);
    push(f3 + 106, "ar_vcnt", VC, 0);   push(f3 + 106, "ar_fcnt", FC, 0);  push(f3 + 106, "ar_uf", UF, 0);
    push(f3 + 106, "ar_ufcnt", UC, 0);
    push(c0 + 616, "rs_idle", ST, 0);   push(c0 + 617, "rs_frst", ST, 1);
    push(c0 + 624, "rs_scan", ST, 3);   push(c0 + 624, "rs_hcnt", HC, 0);
    wait_until(f2 + 65); bus.i_valid = 1'b0;
    wait_until(f2 + 66); bus.i_valid = 1'b1;
    wait_until(f2 + 67); i_clr_err = 1'b1;
    wait_until(f2 + 68); i_clr_err = 1'b0;
    wait_until(f2 + 70); bus.i_valid = 1'b0; i_clr_err = 1'b1;
    wait_until(f2 + 71); bus.i_valid = 1'b1; i_clr_err = 1'b0;
    wait_until(f2 + 80); i_en = 1'b0;
    wait_until(c0 + 500); i_en = 1'b1;
    wait_until(f3 + 104); bus.i_valid = 1'b0;
    wait_until(f3 + 105); bus.i_valid = 1'b1;
    wait_until(f3 + 106); rst_n = 1'b0;
    wait_until(c0 + 616); rst_n = 1'b1;
    wait_until(c0 + 630);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
